ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one byte (e.g. LED command 0xED) from the terminal to the keyboard over the same two open-drain lines the PS/2 receiver listens on.
- Performs the clock-inhibit and request-to-send sequence, shifts data, odd parity and stop on device-generated clocks, then checks the device acknowledge.
- Sits beside the receiver. `tx_busy` gates the receiver, because the receiver also sees the transmit clocks.

---
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts start/data/parity/stop
// on device clocks and records the device acknowledge. Both lines are only ever pulled low.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int RTS_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 375000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic [2:0] dbg_state_o
);

   localparam int MAX_IR  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_RTS       = 3'd2,
      S_SEND      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [9:0]    shift_q;
   logic [3:0]    bitn_q;
   logic          nack_q;
   logic          clk_oe_q;
   logic          data_oe_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic data_meta_q, data_sync_q;
   logic clk_fall;

   // Synchronizers idle at 1 so a reset release never looks like a clock fall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk_in;
         clk_sync_q  <= clk_meta_q;
         clk_prev_q  <= clk_sync_q;
         data_meta_q <= ps2_data_in;
         data_sync_q <= data_meta_q;
      end
   end

   assign clk_fall = clk_prev_q & ~clk_sync_q;
   assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Handshake: tx_start is accepted only in IDLE (tx_busy low); tx_busy stays high from the
   // cycle after acceptance through the tx_done cycle, and tx_data is captured at acceptance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         bitn_q    <= '0;
         nack_q    <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= cnt_d;
         case (state_q)
            S_IDLE: begin
               clk_oe_q  <= 1'b0;
               data_oe_q <= 1'b0;
               busy_q    <= 1'b0;
               cnt_q     <= '0;
               if (tx_start) begin
                  shift_q  <= {1'b1, ~^tx_data, tx_data};
                  bitn_q   <= '0;
                  nack_q   <= 1'b0;
                  clk_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (cnt_q == INH_LAST) begin
                  cnt_q     <= '0;
                  data_oe_q <= 1'b1;
                  state_q   <= S_RTS;
               end
            end
            S_RTS: begin
               if (cnt_q == RTS_LAST) begin
                  cnt_q    <= '0;
                  clk_oe_q <= 1'b0;
                  bitn_q   <= '0;
                  state_q  <= S_SEND;
               end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
               // Timeout wins over any line event in the same cycle.
               if (cnt_q == TO_LAST) begin
                  clk_oe_q  <= 1'b0;
                  data_oe_q <= 1'b0;
                  nack_q    <= 1'b1;
                  done_q    <= 1'b1;
                  err_q     <= 1'b1;
                  state_q   <= S_DONE;
               end else if (state_q == S_SEND) begin
                  if (clk_fall) begin
                     data_oe_q <= ~shift_q[0];
                     shift_q   <= {1'b0, shift_q[9:1]};
                     bitn_q    <= bitn_q + 4'd1;
                     if (bitn_q == 4'd9) state_q <= S_ACK;
                  end
               end else if (state_q == S_ACK) begin
                  data_oe_q <= 1'b0;
                  if (clk_fall) begin
                     nack_q  <= data_sync_q;
                     state_q <= S_WAIT_IDLE;
                  end
               end else begin
                  if (clk_sync_q && data_sync_q) begin
                     done_q  <= 1'b1;
                     err_q   <= nack_q;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               clk_oe_q  <= 1'b0;
               data_oe_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_error    = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-drain line model and a simple PS/2 device that clocks
// the frame in, samples on rising clock edges and acknowledges (or not).
module tb_ps2_host_tx;

   localparam int I = 40;    // inhibit cycles
   localparam int R = 8;     // request-to-send cycles
   localparam int T = 1500;  // timeout cycles
   localparam int H = 20;    // device clock half period

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
   logic [2:0] dbg_state;
   logic       clk_line, data_line;

   assign clk_line  = dev_clk & ~ps2_clk_oe;
   assign data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(I),
      .RTS_CYCLES    (R),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ps2_clk_in (clk_line),
      .ps2_data_in(data_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .dbg_state_o(dbg_state)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int inh_cnt = 0;
   int rts_cnt = 0;
   int dev_falls = 0;

   always @(negedge clock) begin
      if (tx_done) begin
         done_cnt++;
         if (tx_error) err_cnt++;
      end
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      if (ps2_clk_oe && ps2_data_oe) rts_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(negedge clock);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, output logic ok);
      int w;
      w = 0;
      while (done_cnt == d0 && w < 3000) begin
         @(negedge clock);
         w++;
      end
      ok = (done_cnt != d0);
   endtask

   task automatic dev_xfer(input logic ack, output logic [10:0] got, output logic ok);
      int w;
      got = '0;
      w = 0;
      while (!(clk_line && !data_line) && w < I + R + 50) begin
         tick();
         w++;
      end
      ok = (w < I + R + 50);
      if (ok) begin
         repeat (H) tick();
         got[0] = data_line;
         for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            dev_falls++;
            repeat (H) tick();
            dev_clk = 1'b1;
            repeat (H) tick();
            got[i] = data_line;
         end
         if (ack) dev_data = 1'b0;
         repeat (4) tick();
         dev_clk = 1'b0;
         dev_falls++;
         repeat (H) tick();
         dev_clk = 1'b1;
         repeat (4) tick();
         dev_data = 1'b1;
      end
   endtask

   task automatic do_xfer(input logic [7:0] d, input logic par, input logic ack,
                          input logic inject, input string tag);
      int d0, e0, i0, r0;
      logic [10:0] got;
      logic ok, dok;
      d0 = done_cnt;
      e0 = err_cnt;
      i0 = inh_cnt;
      r0 = rts_cnt;
      start_tx(d);
      check({tag, "_busy"}, 32'(tx_busy), 32'd1);
      fork
         dev_xfer(ack, got, ok);
         begin
            if (inject) begin
               repeat (I + R + 100) tick();
               tx_data  = 8'h55;
               tx_start = 1'b1;
               tick();
               tx_start = 1'b0;
            end
         end
      join
      check({tag, "_dev_ok"}, 32'(ok), 32'd1);
      wait_done(d0, dok);
      check({tag, "_done"}, 32'(dok), 32'd1);
      check({tag, "_frame"}, 32'(got), 32'({1'b1, par, d, 1'b0}));
      check({tag, "_inhibit"}, inh_cnt - i0, I);
      check({tag, "_rts"}, rts_cnt - r0, R);
      check({tag, "_error"}, err_cnt - e0, ack ? 0 : 1);
      repeat (50) @(negedge clock);
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_idle_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      check({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
   endtask

   initial begin
      int w, c, d0, f0;
      logic [10:0] got;
      logic ok;

      // Reset state, observed before any clock edge.
      #1;
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_error", 32'(tx_error), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // 0xED: six ones, odd parity bit 1.
      do_xfer(8'hED, 1'b1, 1'b1, 1'b0, "ed");
      // 0x07 (parity 0) then 0xFF (parity 1) back to back.
      do_xfer(8'h07, 1'b0, 1'b1, 1'b0, "x07");
      do_xfer(8'hFF, 1'b1, 1'b1, 1'b0, "xff");
      // Device leaves data high at the acknowledge clock.
      do_xfer(8'hED, 1'b1, 1'b0, 1'b0, "nack");
      // A 0x55 request mid-transfer must be ignored.
      do_xfer(8'hED, 1'b1, 1'b1, 1'b1, "inject");

      // Device never clocks: timeout measured from the clock release.
      d0 = done_cnt;
      start_tx(8'hED);
      w = 0;
      while (ps2_clk_oe && w < I + R + 10) begin
         @(negedge clock);
         w++;
      end
      check("to_release", w, I + R);
      c = 0;
      while (!tx_done && c < T + 10) begin
         @(negedge clock);
         c++;
      end
      check("to_cycles", c, T);
      check("to_error", 32'(tx_error), 32'd1);
      check("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      @(negedge clock);
      check("to_busy_after", 32'(tx_busy), 32'd0);
      repeat (10) @(negedge clock);
      check("to_done_count", done_cnt - d0, 1);

      // Reset asserted while D4 (a 0 for 0xED) is on the line.
      d0 = done_cnt;
      f0 = dev_falls;
      start_tx(8'hED);
      fork
         dev_xfer(1'b1, got, ok);
         begin
            w = 0;
            while (dev_falls < f0 + 5 && w < 2000) begin
               tick();
               w++;
            end
            check("rst_mid_reached", 32'(w < 2000), 32'd1);
            repeat (6) tick();
            check("rst_mid_pre_data_oe", 32'(ps2_data_oe), 32'd1);
            #2;
            reset_n = 1'b0;
            #1;
            check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
            check("rst_mid_busy", 32'(tx_busy), 32'd0);
            repeat (3) tick();
            reset_n = 1'b1;
         end
      join
      repeat (50) @(negedge clock);
      check("rst_mid_no_done", done_cnt - d0, 0);
      check("rst_mid_dev_ok", 32'(ok), 32'd1);

      do_xfer(8'hED, 1'b1, 1'b1, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
